uart_transmitter: RTL

Serialises one byte at a time onto the UART TX line as 8N1 frames (8E1 with parity compiled in). Sits on the transmit side of the UART controller: accepts `trans_data` qualified by a one-cycle `trans_ok` pulse, and reports `trans_busy` so the controller's transmit FIFO drains exactly one byte per frame. Complements the receiver that feeds `recv_data`/`recv_ok`.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_counter.sv | 31 +++
 rtl/uart_transmitter.sv | 117 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmitter and receiver.
// UART_TRANS_PARITY_EN adds an even-parity bit to transmitted frames.
package uart_pkg;

   localparam int UART_DATA_BITS      = 8;
   localparam int UART_CLOCKS_PER_BIT = 868;

`ifdef UART_TRANS_PARITY_EN
   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } uart_tx_state_t;
`else
   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } uart_tx_state_t;
`endif

   function automatic logic even_parity(
      input logic [UART_DATA_BITS-1:0] d
   );
      return ^d;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLOCKS_PER_BIT-1, tick on the last count.
// Clearing restarts the period so each bit starts from a fresh count.
module uart_baud_counter
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = UART_CLOCKS_PER_BIT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);

   localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);

   logic [CW-1:0] r_count;

   assign tick = (r_count == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (clear || tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter (8E1 when UART_TRANS_PARITY_EN is defined).
// One byte per trans_ok pulse; trans_busy gates the next request.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = UART_CLOCKS_PER_BIT
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [UART_DATA_BITS-1:0] trans_data,
   input  logic                      trans_ok,
   output logic                      trans_busy,
   output logic                      overrun,
   output logic                      txd
);

   uart_tx_state_t            r_state;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic [2:0]                r_bit_idx;
   logic                      r_txd;
   logic                      r_overrun;
`ifdef UART_TRANS_PARITY_EN
   logic                      r_parity;
`endif

   logic w_tick;
   logic w_clear;
   logic w_idle;

   assign w_idle     = (r_state == TX_IDLE);
   assign w_clear    = w_idle;
   assign trans_busy = !w_idle || trans_ok;
   assign overrun    = r_overrun;
   assign txd        = r_txd;

   uart_baud_counter #(
      .CLOCKS_PER_BIT (CLOCKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (w_clear),
      .tick    (w_tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= TX_IDLE;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_txd     <= 1'b1;
         r_overrun <= 1'b0;
`ifdef UART_TRANS_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         if (trans_ok && !w_idle) begin
            r_overrun <= 1'b1;
         end
         unique case (r_state)
            TX_IDLE: begin
               r_txd <= 1'b1;
               if (trans_ok) begin
                  r_shift <= trans_data;
                  r_txd   <= 1'b0;
                  r_state <= TX_START;
`ifdef UART_TRANS_PARITY_EN
                  r_parity <= even_parity(trans_data);
`endif
               end
            end
            TX_START: begin
               if (w_tick) begin
                  r_state   <= TX_DATA;
                  r_bit_idx <= '0;
                  r_txd     <= r_shift[0];
               end
            end
            TX_DATA: begin
               if (w_tick) begin
                  if (r_bit_idx == 3'd7) begin
`ifdef UART_TRANS_PARITY_EN
                     r_state <= TX_PARITY;
                     r_txd   <= r_parity;
`else
                     r_state <= TX_STOP;
                     r_txd   <= 1'b1;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_shift   <= {1'b0, r_shift[UART_DATA_BITS-1:1]};
                     r_txd     <= r_shift[1];
                  end
               end
            end
`ifdef UART_TRANS_PARITY_EN
            TX_PARITY: begin
               if (w_tick) begin
                  r_state <= TX_STOP;
                  r_txd   <= 1'b1;
               end
            end
`endif
            TX_STOP: begin
               r_txd <= 1'b1;
               if (w_tick) begin
                  r_state <= TX_IDLE;
               end
            end
            default: begin
               r_state <= TX_IDLE;
               r_txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule
